result_unloader: RTL

- Drains the flat result bus of systolic_array_top into a serial element stream with a valid/ready handshake.
- On result_valid, captures the whole ACCUM_WIDTH*N*N result matrix into a local buffer.
- Emits the matrix in row-major order, one element per handshake.
- Requantizes each element from accumulator format (S15.16) to data format (S5.10), so results can feed the next layer's matrix_a load path.

---
 rtl/result_unloader.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/result_unloader.sv
// result_unloader
// ---------------------------------------------------------------------------
// Drains the flat result bus of systolic_array_top into a serial, row-major
// element stream with a valid/ready handshake. On result_valid, the block
// captures the whole N x N accumulator matrix into a local buffer. It then
// emits one requantized element per transfer.
//
// Requantization converts S15.16 accumulator values to S5.10 data values.
// The value is rounded half toward +inf, arithmetically shifted, and then
// saturated to the signed output range.
//
// Optional build macro: RESULT_UNLOADER_SAT_COUNT_EN
//   When defined, this macro adds two outputs:
//   - sat_count: saturated transfers of the current matrix, sticky at 255.
//   - sat_flag:  the presented element is saturated.
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst          in   asynchronous active-high reset
//   result_valid in   result_flat holds a complete matrix
//   result_flat  in   element (i,j) at [(i*N+j)*ACCUM_WIDTH +: ACCUM_WIDTH]
//   load_ready   out  block can capture a matrix (IDLE)
//   out_valid    out  out_data valid (STREAM)
//   out_ready    in   downstream accepts
//   out_data     out  requantized element
//   out_row      out  row index of out_data
//   out_col      out  column index of out_data
//   out_last     out  element (N-1,N-1) is presented
//   busy         out  high while streaming
//   sat_count    out  (optional) saturated-transfer count
//   sat_flag     out  (optional) presented element saturated
// ---------------------------------------------------------------------------
module result_unloader #(
  parameter int ARRAY_SIZE  = 4,
  parameter int ACCUM_WIDTH = 32,
  parameter int ACCUM_FRAC  = 16,
  parameter int OUT_WIDTH   = 16,
  parameter int OUT_FRAC    = 10
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         result_valid,
  input  logic [ACCUM_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0] result_flat,
  output logic                                         load_ready,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [OUT_WIDTH-1:0]                         out_data,
  output logic [$clog2(ARRAY_SIZE)-1:0]                out_row,
  output logic [$clog2(ARRAY_SIZE)-1:0]                out_col,
  output logic                                         out_last,
  output logic                                         busy
`ifdef RESULT_UNLOADER_SAT_COUNT_EN
  ,
  output logic [7:0]                                   sat_count,
  output logic                                         sat_flag
`endif
);

  localparam int NE = ARRAY_SIZE * ARRAY_SIZE;
  localparam int IW = $clog2(NE);
  localparam int RW = $clog2(ARRAY_SIZE);
  localparam int SH = ACCUM_FRAC - OUT_FRAC;
  // One guard bit so that rounding 0x7FFF_FFFF cannot overflow.
  localparam int TW = ACCUM_WIDTH + 1;

  localparam logic [IW-1:0]        C_LAST = IW'(NE - 1);
  localparam logic [IW-1:0]        C_N    = IW'(ARRAY_SIZE);
  localparam logic signed [TW-1:0] C_RND  = TW'(64'sd1 << (SH - 1));
  localparam logic signed [TW-1:0] C_MAX  = TW'((64'sd1 << (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [TW-1:0] C_MIN  = TW'(-(64'sd1 << (OUT_WIDTH - 1)));

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  // Round half toward +inf and shift; result is still at guard width.
  function automatic logic signed [TW-1:0] rq_shift(input logic [ACCUM_WIDTH-1:0] x);
    logic signed [TW-1:0] t;
    t = $signed({x[ACCUM_WIDTH-1], x}) + C_RND;
    return t >>> SH;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] requant(input logic [ACCUM_WIDTH-1:0] x);
    logic signed [TW-1:0] r;
    logic [OUT_WIDTH-1:0] d;
    r = rq_shift(x);
    if (r > C_MAX) begin
      d = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else if (r < C_MIN) begin
      d = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      d = r[OUT_WIDTH-1:0];
    end
    return d;
  endfunction

  function automatic logic requant_sat(input logic [ACCUM_WIDTH-1:0] x);
    logic signed [TW-1:0] r;
    r = rq_shift(x);
    return (r > C_MAX) || (r < C_MIN);
  endfunction

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [IW-1:0]          r_idx;
  logic [IW-1:0]          w_idx_nxt;
  logic [ACCUM_WIDTH-1:0] r_buf [NE];
  logic                   w_capture;
  logic                   w_xfer;
  logic [ACCUM_WIDTH-1:0] w_elem;

  assign w_elem = r_buf[r_idx];

  // State and element index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Matrix buffer; only written by a capture in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NE; k++) begin
        r_buf[k] <= '0;
      end
    end else if (w_capture) begin
      for (int k = 0; k < NE; k++) begin
        r_buf[k] <= result_flat[k*ACCUM_WIDTH +: ACCUM_WIDTH];
      end
    end
  end

  // Next-state logic and stream outputs.
  // Outputs depend only on registers, so out_ready and result_valid never
  // reach an output combinationally.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_capture   = 1'b0;
    w_xfer      = 1'b0;
    load_ready  = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    out_data    = '0;
    out_row     = '0;
    out_col     = '0;
    out_last    = 1'b0;
    case (r_state)
      S_IDLE: begin
        load_ready = 1'b1;
        if (result_valid) begin
          w_capture   = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = S_STREAM;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_STREAM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = requant(w_elem);
        out_row   = RW'(r_idx / C_N);
        out_col   = RW'(r_idx % C_N);
        out_last  = (r_idx == C_LAST);
        if (out_ready) begin
          w_xfer = 1'b1;
          if (r_idx == C_LAST) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_idx_nxt = r_idx + IW'(1);
          end
        end else begin
          w_idx_nxt = r_idx;
        end
      end
      default: begin
        w_idx_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef RESULT_UNLOADER_SAT_COUNT_EN
  logic [7:0] r_sat_count;
  logic       w_sat;

  assign w_sat     = requant_sat(w_elem);
  assign sat_flag  = (r_state == S_STREAM) && w_sat;
  assign sat_count = r_sat_count;

  // Saturated-transfer counter, cleared per captured matrix, sticky at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat_count <= 8'd0;
    end else if (w_capture) begin
      r_sat_count <= 8'd0;
    end else if (w_xfer && w_sat && (r_sat_count != 8'hFF)) begin
      r_sat_count <= r_sat_count + 8'd1;
    end
  end
`endif

endmodule
